// File: rtl/tb_dina_lane_mapper.sv
// Registered L-lane write-word builder for temp-buffer port A (CB pass/reverse/slot, NL_UPD scalars).
// Optional feature macro: TB_DINA_NL_SNAP_EN (freezes nl_vec on NL entry for the rest of the burst).
module tb_dina_lane_mapper #(
  parameter int L              = 4,
  parameter int X              = 4,
  parameter int RSA_DW         = 32,
  parameter int SEQ_CNT_DW     = 10,
  parameter int TB_DINA_SEL_DW = 5,
  parameter int NL_N           = 2,
  parameter int SLOT_W         = 1,
  parameter int LANE_W         = (L > 1) ? $clog2(L) : 1
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic [TB_DINA_SEL_DW-1:0] TB_dina_sel,
  input  logic                      cb_vld,
  input  logic [SLOT_W-1:0]         new_slot,
  input  logic [LANE_W-1:0]         nl_lane,
  input  logic [SEQ_CNT_DW-1:0]     seq_cnt_out,
  input  logic [L*RSA_DW-1:0]       TB_dina_CB_douta,
  input  logic [NL_N*RSA_DW-1:0]    nl_vec,
  input  logic                      err_clr,
  output logic [L*RSA_DW-1:0]       TB_dina,
  output logic                      TB_dina_vld,
  output logic                      map_err
);

  localparam int SRC_W = TB_DINA_SEL_DW - 2;

  localparam logic [SRC_W-1:0] SRC_CB    = SRC_W'(3'b100);
  localparam logic [SRC_W-1:0] SRC_PRD   = SRC_W'(3'b101);
  localparam logic [SRC_W-1:0] SRC_NEWNL = SRC_W'(3'b110);
  localparam logic [SRC_W-1:0] SRC_NL    = SRC_W'(3'b111);

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_NEW  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CB   = 2'd1;
  localparam logic [1:0] ST_NL   = 2'd2;

  logic [SRC_W-1:0]       src;
  logic [1:0]             dir;
  logic [RSA_DW-1:0]      cb_lane [L];
  logic [L*RSA_DW-1:0]    neg_word;
  logic [L*RSA_DW-1:0]    new_word;
  logic [L*RSA_DW-1:0]    nl_word;
  logic [NL_N*RSA_DW-1:0] nl_src;
  logic [RSA_DW-1:0]      vt_word;
  logic                   seq_ok;
  logic                   slot_ok;
  logic                   nl_entry;
  logic                   err_set;

  logic [L*RSA_DW-1:0] dina_q, dina_d;
  logic                vld_q, vld_d;
  logic                err_q, err_d;
  logic [1:0]          state_q, state_d;

  assign src = TB_dina_sel[TB_DINA_SEL_DW-1:2];
  assign dir = TB_dina_sel[1:0];

  // Candidate words for every mode are built per lane; the select below only picks one.
  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_lane
      assign cb_lane[gi] = TB_dina_CB_douta[gi*RSA_DW +: RSA_DW];

      if (gi < X) begin : g_rev
        assign neg_word[gi*RSA_DW +: RSA_DW] = cb_lane[X-1-gi];
      end else begin : g_rev_zero
        assign neg_word[gi*RSA_DW +: RSA_DW] = '0;
      end

      assign new_word[gi*RSA_DW +: RSA_DW] =
          (int'(new_slot) == gi / 2) ? cb_lane[gi % 2] : '0;

      assign nl_word[gi*RSA_DW +: RSA_DW] =
          (int'(nl_lane) == gi) ? vt_word : '0;
    end
  endgenerate

  assign slot_ok  = int'(new_slot) < (L / 2);
  assign seq_ok   = (seq_cnt_out >= SEQ_CNT_DW'(1)) && (seq_cnt_out <= SEQ_CNT_DW'(NL_N));
  assign nl_entry = (src == SRC_NL) && (state_q != ST_NL);

`ifdef TB_DINA_NL_SNAP_EN
  logic [NL_N*RSA_DW-1:0] snap_q, snap_d;

  // Entry cycle bypasses the snapshot so the first NL word carries no extra latency.
  assign snap_d = nl_entry ? nl_vec : snap_q;
  assign nl_src = nl_entry ? nl_vec : snap_q;

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end
`else
  logic entry_unused;

  assign entry_unused = nl_entry;
  assign nl_src       = nl_vec;
`endif

  always_comb begin
    vt_word = '0;
    for (int k = 0; k < NL_N; k++) begin
      if (int'(seq_cnt_out) == k + 1) begin
        vt_word = nl_src[k*RSA_DW +: RSA_DW];
      end
    end
  end

  always_comb begin
    dina_d  = '0;
    vld_d   = 1'b0;
    err_set = 1'b0;
    case (src)
      SRC_CB: begin
        case (dir)
          DIR_POS: begin
            dina_d = TB_dina_CB_douta;
            vld_d  = cb_vld;
          end
          DIR_NEG: begin
            dina_d = neg_word;
            vld_d  = cb_vld;
          end
          DIR_NEW: begin
            if (slot_ok) begin
              dina_d = new_word;
              vld_d  = cb_vld;
            end else begin
              err_set = 1'b1;
            end
          end
          default: begin
            dina_d = '0;
          end
        endcase
      end
      SRC_NL: begin
        if (seq_ok) begin
          dina_d = nl_word;
          vld_d  = 1'b1;
        end
      end
      SRC_PRD, SRC_NEWNL: begin
        err_set = 1'b1;
      end
      default: begin
        dina_d = '0;
      end
    endcase
  end

  // Set has priority over clear so an error in the clear cycle is never lost.
  assign err_d = err_set | (err_q & ~err_clr);

  always_comb begin
    state_d = ST_IDLE;
    if (src == SRC_CB) begin
      state_d = ST_CB;
    end else if (src == SRC_NL) begin
      state_d = ST_NL;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      dina_q  <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      dina_q  <= dina_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  assign TB_dina     = dina_q;
  assign TB_dina_vld = vld_q;
  assign map_err     = err_q;

endmodule

// File: tb/tb_tb_dina_lane_mapper.sv
// Directed bench for tb_dina_lane_mapper: reset, CB modes, NL_UPD sequencing, error flag, snapshot.
module tb_tb_dina_lane_mapper;

  logic         clk;
  logic         sys_rst;
  logic [4:0]   TB_dina_sel;
  logic         cb_vld;
  logic [0:0]   new_slot;
  logic [1:0]   nl_lane;
  logic [9:0]   seq_cnt_out;
  logic [127:0] TB_dina_CB_douta;
  logic [63:0]  nl_vec;
  logic         err_clr;
  logic [127:0] TB_dina;
  logic         TB_dina_vld;
  logic         map_err;

  int tests_run;
  int tests_failed;

  localparam logic [31:0] A = 32'h0000_00AA;
  localparam logic [31:0] B = 32'hFFFF_FFF0;
  localparam logic [31:0] C = 32'h8000_0001;
  localparam logic [31:0] D = 32'h7FFF_FFFF;
  localparam logic [31:0] Z = 32'h0;

  tb_dina_lane_mapper dut (
    .clk              (clk),
    .sys_rst          (sys_rst),
    .TB_dina_sel      (TB_dina_sel),
    .cb_vld           (cb_vld),
    .new_slot         (new_slot),
    .nl_lane          (nl_lane),
    .seq_cnt_out      (seq_cnt_out),
    .TB_dina_CB_douta (TB_dina_CB_douta),
    .nl_vec           (nl_vec),
    .err_clr          (err_clr),
    .TB_dina          (TB_dina),
    .TB_dina_vld      (TB_dina_vld),
    .map_err          (map_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    // Reset with garbage inputs, including an error-raising select
    sys_rst          = 1'b1;
    TB_dina_sel      = 5'b10100;
    cb_vld           = 1'b1;
    new_slot         = 1'b1;
    nl_lane          = 2'd2;
    seq_cnt_out      = 10'd1;
    TB_dina_CB_douta = {D, C, B, A};
    nl_vec           = {32'h5555, 32'h6666};
    err_clr          = 1'b0;
    step();
    step();
    check("rst_dina", TB_dina, '0);
    check("rst_vld", 128'(TB_dina_vld), 128'(0));
    check("rst_err", 128'(map_err), 128'(0));

    sys_rst          = 1'b0;
    TB_dina_sel      = 5'b10001;
    cb_vld           = 1'b1;
    TB_dina_CB_douta = {32'd4, 32'd3, 32'd2, 32'd1};
    step();
    check("pos_dina", TB_dina, {32'd4, 32'd3, 32'd2, 32'd1});
    check("pos_vld", 128'(TB_dina_vld), 128'(1));

    TB_dina_sel      = 5'b10010;
    TB_dina_CB_douta = {D, C, B, A};
    step();
    check("neg_dina", TB_dina, {A, B, C, D});
    check("neg_vld", 128'(TB_dina_vld), 128'(1));

    TB_dina_sel = 5'b10011;
    new_slot    = 1'b1;
    step();
    check("new1_dina", TB_dina, {B, A, Z, Z});

    new_slot = 1'b0;
    step();
    check("new0_dina", TB_dina, {Z, Z, B, A});
    check("new0_vld", 128'(TB_dina_vld), 128'(1));

    cb_vld = 1'b0;
    step();
    check("cbvld0_vld", 128'(TB_dina_vld), 128'(0));

    cb_vld      = 1'b1;
    TB_dina_sel = 5'b10000;
    step();
    check("idle_dina", TB_dina, '0);
    check("idle_vld", 128'(TB_dina_vld), 128'(0));

    TB_dina_sel = 5'b00001;
    step();
    check("other_dina", TB_dina, '0);
    check("other_err", 128'(map_err), 128'(0));

    // NL_UPD sequence, cb_vld deliberately left high
    TB_dina_sel = 5'b11100;
    nl_lane     = 2'd3;
    nl_vec      = {32'h22, 32'h11};
    for (int s = 0; s < 4; s++) begin
      seq_cnt_out = 10'(s);
      step();
      check($sformatf("nl_seq%0d_vld", s), 128'(TB_dina_vld), 128'((s == 1 || s == 2) ? 1 : 0));
      check($sformatf("nl_seq%0d_dina", s), TB_dina,
            (s == 1) ? {32'h11, Z, Z, Z} : (s == 2) ? {32'h22, Z, Z, Z} : 128'(0));
    end

    nl_lane     = 2'd0;
    seq_cnt_out = 10'd1;
    step();
    check("nl_lane0_dina", TB_dina, {Z, Z, Z, 32'h11});

    // Mode switch without bubble: NL straight to CB
    TB_dina_sel      = 5'b10001;
    TB_dina_CB_douta = {D, C, B, A};
    step();
    check("switch_cb_dina", TB_dina, {D, C, B, A});

    // Errors
    TB_dina_sel = 5'b10100;
    step();
    check("err_prd_flag", 128'(map_err), 128'(1));
    check("err_prd_dina", TB_dina, '0);
    check("err_prd_vld", 128'(TB_dina_vld), 128'(0));

    TB_dina_sel = 5'b10001;
    step();
    check("err_hold", 128'(map_err), 128'(1));

    TB_dina_sel = 5'b11000;
    err_clr     = 1'b1;
    step();
    check("err_set_wins", 128'(map_err), 128'(1));
    check("err_newnl_vld", 128'(TB_dina_vld), 128'(0));

    TB_dina_sel = 5'b10001;
    step();
    check("err_cleared", 128'(map_err), 128'(0));
    err_clr = 1'b0;

    // Snapshot behaviour
    TB_dina_sel = 5'b10000;
    step();
    TB_dina_sel = 5'b11100;
    nl_lane     = 2'd1;
    seq_cnt_out = 10'd1;
    nl_vec      = {32'h22, 32'h11};
    step();
    check("snap_entry", TB_dina, {Z, Z, 32'h11, Z});
    nl_vec = {32'h22, 32'h99};
    step();
`ifdef TB_DINA_NL_SNAP_EN
    check("snap_hold", TB_dina, {Z, Z, 32'h11, Z});
`else
    check("snap_live", TB_dina, {Z, Z, 32'h99, Z});
`endif

    // Re-entry after a CB cycle always sees live data
    TB_dina_sel = 5'b10001;
    step();
    TB_dina_sel = 5'b11100;
    step();
    check("reentry_live", TB_dina, {Z, Z, 32'h99, Z});

    // Reset in the middle of an NL burst
    nl_vec      = {32'h22, 32'h11};
    seq_cnt_out = 10'd1;
    sys_rst     = 1'b1;
    step();
    check("midrst_dina", TB_dina, '0);
    check("midrst_vld", 128'(TB_dina_vld), 128'(0));
    sys_rst     = 1'b0;
    seq_cnt_out = 10'd2;
    step();
    check("midrst_seq2", TB_dina, {Z, Z, 32'h22, Z});
    check("midrst_seq2_vld", 128'(TB_dina_vld), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
